// File: rtl/fetch_unit.sv
// Instruction fetch initiator: drives the word address into a registered-read
// instruction memory and loads the returned word into the IF/ID register.
// Latency: address on o_pc in cycle n, data on i_inst in n+1, IF/ID valid in n+2.
// Backpressure: i_stall holds pc and IF/ID; the in-flight word parks in a
// one-entry skid buffer so the first unstalled edge delivers with no bubble.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   o_pc                  word address presented to instruction memory
//   i_inst                memory read data for the address of the previous edge
//   i_stall               ID cannot accept an instruction this edge
//   i_redirect/_pc        taken branch/jump from EX; flush and refetch at target
//   o_if_inst/_pc/_valid  IF/ID pipeline register
//   o_if_count            number of instructions handed to ID (wraps at 2^32)
//
// MEM_DEPTH must be a power of two; all addresses are kept modulo MEM_DEPTH.
module fetch_unit #(
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned MEM_DEPTH = 128
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_pc,
    input  logic [31:0] i_inst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_if_inst,
    output logic [31:0] o_if_pc,
    output logic        o_if_valid,
    output logic [31:0] o_if_count
);

    localparam logic [31:0] PC_MASK  = 32'(MEM_DEPTH - 1);
    localparam logic [31:0] PC_RESET = 32'(RESET_PC);

    // Address presented to memory this cycle
    logic [31:0] r_pc;
    // Address presented at the previous edge; its data is on i_inst now
    logic [31:0] r_req_pc;
    logic        r_req_v;
    // One-entry skid buffer
    logic [31:0] r_sk_inst;
    logic [31:0] r_sk_pc;
    logic        r_sk_v;
    // IF/ID register
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc;
    logic        r_if_valid;
    logic [31:0] r_if_count;

    logic [31:0] w_pc_inc;
    logic [31:0] w_redirect_pc;

    assign w_pc_inc      = (r_pc + 32'd1) & PC_MASK;
    assign w_redirect_pc = i_redirect_pc & PC_MASK;

    always_ff @(posedge i_clk) begin
        r_req_pc <= r_pc;
        if (i_rst) begin
            r_pc       <= PC_RESET;
            r_req_v    <= 1'b0;
            r_sk_v     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_inst  <= 32'd0;
            r_if_pc    <= 32'd0;
            r_if_count <= 32'd0;
        end else if (i_redirect) begin
            // The word in flight belongs to the wrong path, as does any skid entry.
            r_pc       <= w_redirect_pc;
            r_req_v    <= 1'b0;
            r_sk_v     <= 1'b0;
            r_if_valid <= 1'b0;
        end else if (i_stall) begin
            r_req_v <= 1'b1;
            // With pc held, memory re-reads the same word next cycle, so once
            // the skid is full the returning word can simply be dropped.
            if (r_req_v && !r_sk_v) begin
                r_sk_inst <= i_inst;
                r_sk_pc   <= r_req_pc;
                r_sk_v    <= 1'b1;
            end
        end else begin
            r_req_v <= 1'b1;
            r_pc    <= w_pc_inc;
            if (r_sk_v) begin
                // The skid holds the older word; the word now on i_inst is the
                // one pc pointed at during the stall and gets refetched.
                r_if_inst  <= r_sk_inst;
                r_if_pc    <= r_sk_pc;
                r_if_valid <= 1'b1;
                r_sk_v     <= 1'b0;
                r_if_count <= r_if_count + 32'd1;
            end else begin
                r_if_inst  <= i_inst;
                r_if_pc    <= r_req_pc;
                r_if_valid <= r_req_v;
                if (r_req_v) begin
                    r_if_count <= r_if_count + 32'd1;
                end
            end
        end
    end

    assign o_pc       = r_pc;
    assign o_if_inst  = r_if_inst;
    assign o_if_pc    = r_if_pc;
    assign o_if_valid = r_if_valid;
    assign o_if_count = r_if_count;

endmodule
